// File: rtl/fib_req_scheduler_if.sv
// Requester-side bus of the Fibonacci request scheduler: four requesters share
// one request/accept/response channel.
interface fib_req_scheduler_if #(
  parameter int unsigned N = 32
);
  logic [3:0]   req_valid;
  logic [19:0]  req_n;
  logic [3:0]   req_ready;
  logic [3:0]   rsp_valid;
  logic [N-1:0] rsp_data;
  logic         rsp_err;

  modport master (
    output req_valid, req_n,
    input  req_ready, rsp_valid, rsp_data, rsp_err
  );

  modport slave (
    input  req_valid, req_n,
    output req_ready, rsp_valid, rsp_data, rsp_err
  );
endinterface

// File: rtl/fib_req_scheduler.sv
// Round-robin scheduler sharing one Fibonacci engine among four requesters.
// Optional WAIT timeout is built only when FIB_SCHED_TIMEOUT_EN is defined.
module fib_req_scheduler #(
  parameter int unsigned N           = 32,
  parameter int unsigned TIMEOUT_CYC = 64
) (
  input  logic                 clk,
  input  logic                 rst,
  fib_req_scheduler_if.slave   bus,
  output logic                 busy,
  output logic                 eng_start,
  output logic [4:0]           eng_in,
  input  logic                 eng_ready,
  input  logic                 eng_done,
  input  logic [N-1:0]         eng_fib
);

  localparam int unsigned NREQ  = 4;
  localparam int unsigned IDX_W = 5;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } state_t;

  state_t           state;
  logic [1:0]       rr_ptr;
  logic [1:0]       owner;
  logic [IDX_W-1:0] n_lat;
  logic [NREQ-1:0]  req_ready_q;
  logic [NREQ-1:0]  rsp_valid_q;
  logic [N-1:0]     rsp_data_q;

  logic             grant_hit;
  logic [1:0]       grant_idx;
  logic [IDX_W-1:0] n_sel;

  // First active requester strictly after rr_ptr, wrapping modulo four.
  always_comb begin
    grant_hit = 1'b0;
    grant_idx = 2'd0;
    for (int k = 1; k <= NREQ; k++) begin
      if (!grant_hit && bus.req_valid[2'(rr_ptr + 2'(k))]) begin
        grant_hit = 1'b1;
        grant_idx = 2'(rr_ptr + 2'(k));
      end
    end
  end

  assign n_sel = bus.req_n[32'(grant_idx) * IDX_W +: IDX_W];

`ifdef FIB_SCHED_TIMEOUT_EN
  localparam int unsigned TMO_W = $clog2(TIMEOUT_CYC + 1);
  logic [TMO_W-1:0] tmo_cnt;
  logic             rsp_err_q;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      rr_ptr      <= 2'd3;
      owner       <= 2'd0;
      n_lat       <= '0;
      req_ready_q <= '0;
      rsp_valid_q <= '0;
      rsp_data_q  <= '0;
      busy        <= 1'b0;
      eng_start   <= 1'b0;
      eng_in      <= '0;
`ifdef FIB_SCHED_TIMEOUT_EN
      tmo_cnt     <= '0;
      rsp_err_q   <= 1'b0;
`endif
    end else begin
      req_ready_q <= '0;
      rsp_valid_q <= '0;
      eng_start   <= 1'b0;
      eng_in      <= '0;
      case (state)
        IDLE: begin
          if (grant_hit) begin
            req_ready_q <= NREQ'(1) << grant_idx;
            owner       <= grant_idx;
            n_lat       <= n_sel;
            busy        <= 1'b1;
            state       <= ISSUE;
          end
        end
        ISSUE: begin
          if (eng_ready) begin
            eng_start <= 1'b1;
            eng_in    <= n_lat;
            state     <= WAIT;
`ifdef FIB_SCHED_TIMEOUT_EN
            tmo_cnt   <= '0;
`endif
          end
        end
        WAIT: begin
          // The response strobe is registered here so it is visible during RESP.
          if (eng_done) begin
            rsp_data_q  <= eng_fib;
            rsp_valid_q <= NREQ'(1) << owner;
            state       <= RESP;
`ifdef FIB_SCHED_TIMEOUT_EN
            rsp_err_q   <= 1'b0;
          end else if (tmo_cnt == TMO_W'(TIMEOUT_CYC - 1)) begin
            tmo_cnt     <= TMO_W'(TIMEOUT_CYC);
            rsp_data_q  <= '0;
            rsp_err_q   <= 1'b1;
            rsp_valid_q <= NREQ'(1) << owner;
            state       <= RESP;
          end else begin
            tmo_cnt     <= tmo_cnt + TMO_W'(1);
`endif
          end
        end
        RESP: begin
          rr_ptr <= owner;
          busy   <= 1'b0;
          state  <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.req_ready = req_ready_q;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_data  = rsp_data_q;
`ifdef FIB_SCHED_TIMEOUT_EN
  assign bus.rsp_err   = rsp_err_q;
`else
  assign bus.rsp_err   = 1'b0;
`endif

endmodule

// File: tb/tb_fib_req_scheduler.sv
// Self-checking bench for fib_req_scheduler with a behavioural engine of
// programmable done delay and a plain-arithmetic Fibonacci reference.
module tb_fib_req_scheduler;

  localparam int unsigned N   = 32;
  localparam int unsigned TMO = 8;

  logic         clk;
  logic         rst;
  logic         busy;
  logic         eng_start;
  logic [4:0]   eng_in;
  logic         eng_ready;
  logic         eng_done;
  logic [N-1:0] eng_fib;

  fib_req_scheduler_if #(.N(N)) bus ();

  fib_req_scheduler #(.N(N), .TIMEOUT_CYC(TMO)) dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus),
    .busy      (busy),
    .eng_start (eng_start),
    .eng_in    (eng_in),
    .eng_ready (eng_ready),
    .eng_done  (eng_done),
    .eng_fib   (eng_fib)
  );

  int vectors     = 0;
  int miscompares = 0;
  int model_ptr   = 3;
  int eng_delay   = 1;
  bit eng_hang    = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [N-1:0] fib_ref(input int n);
    longint a = 0;
    longint b = 1;
    longint t;
    for (int i = 0; i < n; i++) begin
      t = a + b;
      a = b;
      b = t;
    end
    return N'(a);
  endfunction

  function automatic logic [3:0] onehot(input int i);
    logic [3:0] one = 4'b0001;
    return one << i;
  endfunction

  // Engine: samples a start mid-cycle, raises done D cycles after the start cycle.
  initial begin
    int n;
    eng_done = 1'b0;
    eng_fib  = '0;
    forever begin
      @(negedge clk);
      if (eng_start && !eng_hang) begin
        n = int'(eng_in);
        repeat (eng_delay) @(posedge clk);
        #1;
        eng_done = 1'b1;
        eng_fib  = fib_ref(n);
        @(posedge clk);
        #1;
        eng_done = 1'b0;
        eng_fib  = N'($urandom);
      end
    end
  end

  task automatic test_reset();
    rst = 1'b1;
    eng_ready = 1'b1;
    bus.req_valid = '0;
    bus.req_n = '0;
    repeat (3) @(negedge clk);
    vectors++;
    if ({bus.req_ready, bus.rsp_valid, bus.rsp_err, busy, eng_start, eng_in} !== '0)
      $display("FAIL reset_ctrl: got %b expected 0",
               {bus.req_ready, bus.rsp_valid, bus.rsp_err, busy, eng_start, eng_in});
    vectors++;
    if (bus.rsp_data !== '0) begin
      miscompares++;
      $display("FAIL reset_data: got %0d expected 0", bus.rsp_data);
    end
    if ({bus.req_ready, bus.rsp_valid, bus.rsp_err, busy, eng_start, eng_in} !== '0)
      miscompares++;
    rst = 1'b0;
    repeat (2) @(negedge clk);
    vectors++;
    if (busy !== 1'b0 || bus.req_ready !== 4'b0) begin
      miscompares++;
      $display("FAIL idle_after_reset: busy %b ready %b expected 0 0", busy, bus.req_ready);
    end
    model_ptr = 3;
  endtask

  // One isolated transaction with optional eng_ready stall in ISSUE.
  task automatic run_one(input int id, input logic [4:0] n, input int d, input int stall);
    int k;
    int starts;
    bit got;
    eng_delay = d;
    @(negedge clk);
    bus.req_n = 20'($urandom);
    bus.req_n[id*5 +: 5] = n;
    bus.req_valid = onehot(id);
    got = 0;
    for (int c = 0; c < 20 && !got; c++) begin
      @(negedge clk);
      if (bus.req_ready != 4'b0) got = 1;
    end
    vectors++;
    if (!got || bus.req_ready !== onehot(id)) begin
      miscompares++;
      $display("FAIL accept: got %b expected %b", bus.req_ready, onehot(id));
      bus.req_valid = '0;
      return;
    end
    bus.req_valid = '0;
    bus.req_n = 20'($urandom);
    if (stall > 0) eng_ready = 1'b0;
    k = 0;
    starts = 0;
    got = 0;
    while (!got && k < d + stall + 40) begin
      @(negedge clk);
      k++;
      if (stall > 0 && k <= stall) begin
        vectors++;
        if (eng_start !== 1'b0) begin
          miscompares++;
          $display("FAIL stall_start: got %b expected 0 at cycle %0d", eng_start, k);
        end
      end
      if (k == stall) eng_ready = 1'b1;
      vectors++;
      if (eng_start === 1'b1) begin
        starts++;
        if (eng_in !== n) begin
          miscompares++;
          $display("FAIL eng_in: got %0d expected %0d", eng_in, n);
        end
      end else if (eng_in !== 5'd0) begin
        miscompares++;
        $display("FAIL eng_in_idle: got %0d expected 0", eng_in);
      end
      if (bus.rsp_valid != 4'b0) got = 1;
    end
    eng_ready = 1'b1;
    vectors++;
    if (!got) begin
      miscompares++;
      $display("FAIL rsp_timeout: got no response expected one within %0d cycles", k);
      return;
    end
    vectors++;
    if (k != 2 + d + stall) begin
      miscompares++;
      $display("FAIL latency: got %0d expected %0d", k, 2 + d + stall);
    end
    vectors++;
    if (bus.rsp_valid !== onehot(id) || bus.rsp_data !== fib_ref(int'(n)) || bus.rsp_err !== 1'b0) begin
      miscompares++;
      $display("FAIL rsp: got v=%b d=%0d e=%b expected v=%b d=%0d e=0",
               bus.rsp_valid, bus.rsp_data, bus.rsp_err, onehot(id), fib_ref(int'(n)));
    end
    vectors++;
    if (starts != 1 || busy !== 1'b1) begin
      miscompares++;
      $display("FAIL starts_busy: got starts=%0d busy=%b expected 1 1", starts, busy);
    end
    model_ptr = id;
    @(negedge clk);
    vectors++;
    if (bus.rsp_valid !== 4'b0 || busy !== 1'b0 || bus.rsp_data !== fib_ref(int'(n))) begin
      miscompares++;
      $display("FAIL after_rsp: got v=%b busy=%b d=%0d expected 0 0 %0d",
               bus.rsp_valid, busy, bus.rsp_data, fib_ref(int'(n)));
    end
  endtask

  task automatic test_single();
    run_one(0, 5'd10, 10, 0);
  endtask

  task automatic test_boundaries();
    run_one(1, 5'd0, 3, 0);
    run_one(2, 5'd1, 1, 0);
    run_one(3, 5'd31, 4, 0);
  endtask

  task automatic test_stall();
    run_one(int'($urandom_range(0, 3)), 5'd7, 3, 5);
  endtask

  task automatic test_random();
    for (int i = 0; i < 10; i++)
      run_one(int'($urandom_range(0, 3)), 5'($urandom), int'($urandom_range(1, 6)),
              int'($urandom_range(0, 2)));
  endtask

  // Requesters in mask hold req_valid across several passes.
  task automatic test_held(input logic [3:0] mask, input int passes);
    logic [19:0] pn;
    int p;
    int exp_g;
    int cur;
    int grants;
    int resps;
    int cyc;
    pn = 20'($urandom);
    p = model_ptr;
    cur = -1;
    grants = 0;
    resps = 0;
    cyc = 0;
    eng_delay = int'($urandom_range(1, 4));
    @(negedge clk);
    bus.req_n = pn;
    bus.req_valid = mask;
    while (resps < passes && cyc < 60 * passes) begin
      @(negedge clk);
      cyc++;
      if (bus.req_ready != 4'b0) begin
        exp_g = -1;
        for (int j = 1; j <= 4; j++)
          if (exp_g < 0 && mask[(p + j) % 4]) exp_g = (p + j) % 4;
        grants++;
        cur = exp_g;
        vectors++;
        if (bus.req_ready !== onehot(exp_g)) begin
          miscompares++;
          $display("FAIL rr_grant: got %b expected %b", bus.req_ready, onehot(exp_g));
        end
      end
      if (bus.rsp_valid != 4'b0) begin
        vectors++;
        if (cur < 0 || bus.rsp_valid !== onehot(cur) || bus.rsp_data !== fib_ref(int'(pn[cur*5 +: 5]))) begin
          miscompares++;
          $display("FAIL rr_rsp: got v=%b d=%0d expected owner %0d", bus.rsp_valid, bus.rsp_data, cur);
        end
        if (cur >= 0) p = cur;
        resps++;
        if (resps == passes) bus.req_valid = '0;
      end
    end
    bus.req_valid = '0;
    vectors++;
    if (resps != passes || grants != passes) begin
      miscompares++;
      $display("FAIL rr_count: got grants=%0d resps=%0d expected %0d", grants, resps, passes);
    end
    model_ptr = p;
    @(negedge clk);
    vectors++;
    if (busy !== 1'b0 || bus.req_ready !== 4'b0) begin
      miscompares++;
      $display("FAIL rr_idle: got busy=%b ready=%b expected 0 0", busy, bus.req_ready);
    end
  endtask

  task automatic test_reset_mid();
    bit got;
    bit bad;
    eng_delay = 20;
    @(negedge clk);
    bus.req_n = 20'($urandom);
    bus.req_valid = 4'b0100;
    got = 0;
    for (int c = 0; c < 40 && !got; c++) begin
      @(negedge clk);
      if (bus.req_ready != 4'b0) bus.req_valid = '0;
      if (eng_start === 1'b1) got = 1;
    end
    bus.req_valid = '0;
    vectors++;
    if (!got) begin
      miscompares++;
      $display("FAIL mid_start: got no eng_start expected one");
    end
    repeat (3) @(negedge clk);
    rst = 1'b1;
    #1;
    vectors++;
    if (busy !== 1'b0) begin
      miscompares++;
      $display("FAIL mid_async: got busy=%b expected 0", busy);
    end
    @(negedge clk);
    rst = 1'b0;
    model_ptr = 3;
    bad = 0;
    for (int c = 0; c < 30; c++) begin
      @(negedge clk);
      if (bus.rsp_valid !== 4'b0 || busy !== 1'b0) bad = 1;
    end
    vectors++;
    if (bad) begin
      miscompares++;
      $display("FAIL late_done: got response or busy after reset expected none");
    end
    test_held(4'b1111, 1);
  endtask

  task automatic test_timeout();
    int k;
    bit got;
    bit bad;
    eng_hang = 1;
    @(negedge clk);
    bus.req_n = 20'($urandom);
    bus.req_valid = 4'b0010;
    got = 0;
    for (int c = 0; c < 20 && !got; c++) begin
      @(negedge clk);
      if (bus.req_ready != 4'b0) got = 1;
    end
    bus.req_valid = '0;
    vectors++;
    if (!got) begin
      miscompares++;
      $display("FAIL tmo_accept: got no accept expected one");
    end
`ifdef FIB_SCHED_TIMEOUT_EN
    k = 0;
    got = 0;
    while (!got && k < 60) begin
      @(negedge clk);
      k++;
      if (bus.rsp_valid != 4'b0) got = 1;
    end
    vectors++;
    if (!got || k != 1 + TMO || bus.rsp_valid !== 4'b0010 || bus.rsp_err !== 1'b1 || bus.rsp_data !== '0) begin
      miscompares++;
      $display("FAIL timeout_rsp: got k=%0d v=%b e=%b d=%0d expected k=%0d v=0010 e=1 d=0",
               k, bus.rsp_valid, bus.rsp_err, bus.rsp_data, 1 + TMO);
    end
    @(negedge clk);
    model_ptr = 1;
    eng_hang = 0;
`else
    k = 0;
    bad = 0;
    repeat (100) begin
      @(negedge clk);
      k++;
      if (busy !== 1'b1 || bus.rsp_valid !== 4'b0) bad = 1;
    end
    vectors++;
    if (bad) begin
      miscompares++;
      $display("FAIL wait_hold: got busy drop or response within %0d cycles expected none", k);
    end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    eng_hang = 0;
    model_ptr = 3;
    @(negedge clk);
`endif
  endtask

  initial begin
    test_reset();
    test_single();
    test_boundaries();
    test_held(4'b1111, 5);
    test_held(4'b0100, 3);
    test_held(4'($urandom_range(1, 15)), 4);
    test_stall();
    test_random();
    test_reset_mid();
    test_timeout();
    run_one(0, 5'd20, 2, 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
